// File: rtl/risc_isa_pkg.sv
// Shared ISA definitions for the 16-bit instruction format: opcodes, field
// positions, loader error codes and loader FSM states.
package risc_isa_pkg;

  localparam logic [3:0] OP_RTYPE_MAX = 4'd4;
  localparam logic [3:0] OP_BEQ       = 4'd5;
  localparam logic [3:0] OP_LOAD      = 4'd6;

  // Nibble positions within the 16-bit instruction word.
  localparam int FLD_OP_LSB = 12;
  localparam int FLD_A_LSB  = 8;
  localparam int FLD_B_LSB  = 4;
  localparam int FLD_C_LSB  = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILL_OP  = 2'b01;
  localparam logic [1:0] ERR_IMM_OVF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } loader_state_e;

endpackage

// File: rtl/instr_encode.sv
// Combinational instruction packer: fields in, 16-bit word out, with flags
// telling whether the word is writable or the immediate does not fit.
module instr_encode
  import risc_isa_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [3:0]  i_rs,
  input  logic [3:0]  i_rt,
  input  logic [3:0]  i_rd,
  input  logic [7:0]  i_imm,
  output logic [15:0] o_word,
  output logic        o_legal,
  output logic        o_imm_ovf
);

  // Opcode-dependent field placement; LOAD puts the destination ahead of the base.
  always_comb begin
    o_word    = 16'h0000;
    o_legal   = 1'b0;
    o_imm_ovf = 1'b0;
    o_word[FLD_OP_LSB +: 4] = i_opcode;
    if (i_opcode <= OP_RTYPE_MAX) begin
      o_word[FLD_A_LSB +: 4] = i_rs;
      o_word[FLD_B_LSB +: 4] = i_rt;
      o_word[FLD_C_LSB +: 4] = i_rd;
      o_legal = 1'b1;
    end else if (i_opcode == OP_BEQ) begin
      o_word[FLD_A_LSB +: 4] = i_rs;
      o_word[FLD_B_LSB +: 4] = i_rt;
      o_word[FLD_C_LSB +: 4] = i_imm[3:0];
      o_imm_ovf = |i_imm[7:4];
      o_legal   = ~(|i_imm[7:4]);
    end else if (i_opcode == OP_LOAD) begin
      o_word[FLD_A_LSB +: 4] = i_rd;
      o_word[FLD_B_LSB +: 4] = i_rs;
      o_word[FLD_C_LSB +: 4] = i_imm[3:0];
      o_imm_ovf = |i_imm[7:4];
      o_legal   = ~(|i_imm[7:4]);
    end else begin
      o_legal = 1'b0;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams instruction fields in, encodes them and writes them sequentially
// into instruction memory from a base address; flags unencodable beats.
module instr_mem_loader
  import risc_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [3:0]        in_rd,
  input  logic [7:0]        in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  loader_state_e     r_state;
  loader_state_e     w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;

  logic [15:0] w_word;
  logic        w_legal;
  logic        w_imm_ovf;
  logic        w_acc;
  logic        w_wr_done;
  logic        w_last;

  instr_encode u_encode (
    .i_opcode  (in_opcode),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_legal   (w_legal),
    .o_imm_ovf (w_imm_ovf)
  );

  // A held write that completes this cycle frees the output register for a new beat.
  assign in_ready  = (r_state == ST_RUN) && (r_cnt < r_len) && (!r_we || mem_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_wr_done = r_we && mem_ready;
  assign w_last    = w_acc && w_legal && ((r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1}) == r_len);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && (length != {ADDR_W{1'b0}})) w_next = ST_RUN;
        else                                     w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_FLUSH;
        else        w_next = ST_RUN;
      end
      ST_FLUSH: begin
        if (w_wr_done) w_next = ST_IDLE;
        else           w_next = ST_FLUSH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Session registers, write output register and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= {ADDR_W{1'b0}};
      r_len   <= {ADDR_W{1'b0}};
      r_cnt   <= {ADDR_W{1'b0}};
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_base <= base_addr;
          r_len  <= length;
          r_cnt  <= {ADDR_W{1'b0}};
          r_err  <= ERR_NONE;
          r_busy <= (length != {ADDR_W{1'b0}});
          r_done <= (length == {ADDR_W{1'b0}});
        end
      end else begin
        if (w_wr_done) r_we <= 1'b0;
        if (w_acc) begin
          if (w_legal) begin
            r_we    <= 1'b1;
            r_addr  <= r_base + r_cnt;
            r_wdata <= w_word;
            r_cnt   <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else if (r_err == ERR_NONE) begin
            r_err <= w_imm_ovf ? ERR_IMM_OVF : ERR_ILL_OP;
          end
        end
        if ((r_state == ST_FLUSH) && w_wr_done) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_code  = r_err;

endmodule
